dif_radix2_64p_da_ctrl: RTL and testbench
=========================================

DIF_RADIX2_64P_DA_CTRL -- requirements
Module: dif_radix2_64p_da_ctrl

Interface
REQ-001 SHALL have parameter RF_DEPTH, default 8: banks in the data arranger, each 8 entries deep; only 8 is supported.
REQ-002 SHALL have parameter RD_LAT, default 1: arranger read latency in cycles from read strobe to dout; legal range 1..3.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input sample is present on the arranger din this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: controller accepts a sample this cycle.
REQ-007 SHALL have port wen_ctrl, output, RF_DEPTH bits: one-hot bank write enable.
REQ-008 SHALL have port waddr_ctrl, output, 3 bits: write entry address.
REQ-009 SHALL have port ren_ctrl, output, RF_DEPTH bits: one-hot bank read enable.
REQ-010 SHALL have port raddr_ctrl, output, 3 bits: read entry address.
REQ-011 SHALL have port out_valid, output, 1 bit: arranger dout holds a valid sample.
REQ-012 SHALL have port out_index, output, 6 bits: output sample position m for the current dout.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the 64th out_valid.

Function
REQ-014 SHALL implement states IDLE, WRITE and READ; a sample is accepted when in_valid and in_ready are both high.
REQ-015 SHALL set in_ready from a register: 1 in IDLE and WRITE, 0 in READ.
REQ-016 SHALL use a 6-bit write counter wcnt; on acceptance: wen_ctrl = onehot(wcnt[5:3]), waddr_ctrl = wcnt[2:0], both combinational, same cycle as din; otherwise wen_ctrl = 0.
REQ-017 SHALL, in IDLE, move to WRITE on the first acceptance; when wcnt=63 is accepted, clear in_ready, reset wcnt to 0 and enter READ at the next edge.
REQ-018 SHALL leave wcnt unchanged on an in_valid gap during WRITE, with no timeout.
REQ-019 SHALL, in READ, step a 6-bit counter rcnt from 0 to 63, one per cycle with no stalls, and drive ren_ctrl = onehot(rcnt[2:0]) and raddr_ctrl = rcnt[5:3], both registered; ren_ctrl = 0 outside READ.
REQ-020 SHALL therefore output m = 8*(n mod 8) + n/8, where n is the input index (8x8 transpose).
REQ-021 SHALL return to IDLE, with in_ready=1, on the edge after the rcnt=63 strobe; a new frame's first write MAY occur that cycle.
REQ-022 SHALL produce out_valid and out_index as the read strobe and rcnt delayed by RD_LAT cycles through a shift pipeline.
REQ-023 SHALL assert frame_done when out_valid is high and out_index=63.
REQ-024 SHALL make READ duration exactly 64 cycles; frame latency from the last acceptance to the first out_valid is 1+RD_LAT cycles.

Reset
REQ-025 SHALL, while rst_n=0, force: state IDLE, wcnt=rcnt=0, in_ready=0, wen_ctrl=0, waddr_ctrl=0, ren_ctrl=0, raddr_ctrl=0, out_valid=0, out_index=0, frame_done=0, and all pipeline stages cleared.
REQ-026 SHALL raise in_ready at the first clock edge after rst_n deasserts.
REQ-027 SHALL, on reset assertion mid-frame, discard the partial frame; no out_valid follows until a complete new frame is written.

Configuration
REQ-028 SHALL, when DA_CTRL_ERR_EN is defined, add output err (1 bit, reset 0), set sticky when in_valid=1 while in_ready=0 and cleared only by reset.
REQ-029 SHALL, without DA_CTRL_ERR_EN, have no err port; in_valid while in_ready=0 is ignored silently.

Structure
REQ-030 SHALL place the state encoding (IDLE/WRITE/READ), frame size 64, bank count 8 and the onehot-of-3-bit function in a shared package, dif_radix2_64p_pkg.
REQ-031 SHALL use one sub-module, da_ctrl_dly: a parameterized RD_LAT-stage valid/index delay line with asynchronous reset.

Verification
REQ-032 SHALL cover: 64 back-to-back samples with value = n -> wen_ctrl one-hot on bank n/8, waddr=n%8; in_ready=0 for exactly 64 cycles.
REQ-033 SHALL cover: same frame through an arranger model -> dout sequence 0,8,16,...,56,1,9,...,63; frame_done with value 63.
REQ-034 SHALL cover: a random in_valid gap pattern (50% duty) -> identical output order; READ still exactly 64 contiguous cycles.
REQ-035 SHALL cover: rst_n pulled low after 20 accepted samples, then a full frame -> only the new frame's 64 outputs appear.
REQ-036 SHALL cover: with DA_CTRL_ERR_EN, in_valid=1 during READ cycle 10 -> err=1 and held until reset; without the macro -> no effect.
REQ-037 SHALL cover: RD_LAT=3 and two consecutive frames -> first out_valid 4 cycles after the last acceptance; the second frame's writes begin the cycle after the last read strobe with no data corruption.

Source files
------------

// File: rtl/dif_radix2_64p_pkg.sv
// -----------------------------------------------------------------------------
// dif_radix2_64p_pkg
// Shared definitions for the 64-point DIF radix-2 data-arranger controller:
// FSM state encoding, frame/bank geometry and the 3-bit to one-hot decoder
// used for bank write/read enables.
// No ports (package).
// -----------------------------------------------------------------------------
package dif_radix2_64p_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } da_state_t;

  localparam int FRAME_SIZE = 64;
  localparam int N_BANKS    = 8;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] CNT_LAST = 6'd63;

  // Bank select decoder: bit 'sel' of the result is set.
  function automatic logic [N_BANKS-1:0] onehot3(input logic [2:0] sel);
    onehot3 = 8'b0000_0001 << sel;
  endfunction

endpackage

// File: rtl/da_ctrl_dly.sv
// -----------------------------------------------------------------------------
// da_ctrl_dly
// LAT-stage shift pipeline that carries the read strobe and read index
// alongside the data arranger's read latency, so vld/idx line up with dout.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears every stage
//   stb    in   read strobe issued this cycle
//   cnt    in   read index (output position m) of this strobe
//   vld    out  strobe delayed by LAT cycles
//   idx    out  index delayed by LAT cycles
// -----------------------------------------------------------------------------
module da_ctrl_dly #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stb,
  input  logic [5:0] cnt,
  output logic       vld,
  output logic [5:0] idx
);

  logic [LAT-1:0] vld_q;
  logic [5:0]     idx_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= stb;
      idx_q[0] <= cnt;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign vld = vld_q[LAT-1];
  assign idx = idx_q[LAT-1];

endmodule

// File: rtl/dif_radix2_64p_da_ctrl.sv
// -----------------------------------------------------------------------------
// dif_radix2_64p_da_ctrl
// Write/read sequencer for an 8-bank x 8-entry data arranger that performs the
// 8x8 transpose (m = 8*(n mod 8) + n/8) between FFT stages.
//
// A frame of 64 samples is written bank-major (bank n/8, entry n%8), then read
// out in 64 contiguous cycles entry-major (bank r%8, entry r/8).
//
//   state | meaning
//   IDLE  | waiting for the first sample of a frame, in_ready=1
//   WRITE | collecting samples 1..63, gaps on in_valid are allowed
//   READ  | 64 back-to-back read strobes, in_ready=0
//
// Parameters:
//   RF_DEPTH  number of arranger banks (8 entries each); only 8 is supported
//   RD_LAT    arranger read latency, read strobe to dout, 1..3
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   sample present on arranger din
//   in_ready    out  sample accepted this cycle (registered)
//   wen_ctrl    out  one-hot bank write enable (combinational, with din)
//   waddr_ctrl  out  write entry address (combinational)
//   ren_ctrl    out  one-hot bank read enable (registered)
//   raddr_ctrl  out  read entry address (registered)
//   out_valid   out  arranger dout holds a valid sample
//   out_index   out  output position m of the current dout
//   frame_done  out  pulse with the 64th out_valid of a frame
//   err         out  (only with DA_CTRL_ERR_EN) sticky: in_valid seen while
//                    in_ready=0; cleared by reset only
//
// Build option: define DA_CTRL_ERR_EN to add the err output.
// -----------------------------------------------------------------------------
module dif_radix2_64p_da_ctrl
  import dif_radix2_64p_pkg::*;
#(
  parameter int RF_DEPTH = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [RF_DEPTH-1:0] wen_ctrl,
  output logic [2:0]          waddr_ctrl,
  output logic [RF_DEPTH-1:0] ren_ctrl,
  output logic [2:0]          raddr_ctrl,
  output logic                out_valid,
  output logic [5:0]          out_index,
  output logic                frame_done
`ifdef DA_CTRL_ERR_EN
  ,
  output logic                err
`endif
);

  da_state_t        state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic             accept;
  logic             rd_nxt;

  assign accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and combinational write-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    rcnt_nxt   = rcnt;
    wen_ctrl   = '0;
    waddr_ctrl = wcnt[2:0];

    if (accept) begin
      wen_ctrl = onehot3(wcnt[5:3]);
    end

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_WRITE;
          wcnt_nxt  = wcnt + 6'd1;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          if (wcnt == CNT_LAST) begin
            state_nxt = ST_READ;
            wcnt_nxt  = '0;
            rcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + 6'd1;
          end
        end
      end
      ST_READ: begin
        if (rcnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          rcnt_nxt  = '0;
        end else begin
          rcnt_nxt = rcnt + 6'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        wcnt_nxt  = '0;
        rcnt_nxt  = '0;
      end
    endcase
  end

  assign rd_nxt = (state_nxt == ST_READ);

  // ---------------------------------------------------------------------------
  // Registered handshake and read-side outputs. They are loaded from the
  // next-state values so that in_ready/ren_ctrl/raddr_ctrl are valid in the
  // same cycle the FSM is in the corresponding state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      ren_ctrl   <= '0;
      raddr_ctrl <= '0;
    end else begin
      in_ready   <= ~rd_nxt;
      ren_ctrl   <= rd_nxt ? onehot3(rcnt_nxt[2:0]) : '0;
      raddr_ctrl <= rd_nxt ? rcnt_nxt[5:3] : 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Align valid/index with the arranger's read latency
  // ---------------------------------------------------------------------------
  da_ctrl_dly #(
    .LAT (RD_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .stb   (state == ST_READ),
    .cnt   (rcnt),
    .vld   (out_valid),
    .idx   (out_index)
  );

  assign frame_done = out_valid && (out_index == CNT_LAST);

`ifdef DA_CTRL_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dif_radix2_64p_da_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dif_radix2_64p_da_ctrl
// Two controllers (RD_LAT=1 and RD_LAT=3) driven by the same in_valid, each
// feeding its own 8x8 arranger memory. Output order, index, frame_done and
// first-output latency are compared with hand-derived transpose values.
// Build option: DA_CTRL_ERR_EN adds the err output to both instances.
// -----------------------------------------------------------------------------
module tb_dif_radix2_64p_da_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] din = 8'd0;

  always #5 clk = ~clk;

  logic       in_ready   [2];
  logic [7:0] wen        [2];
  logic [2:0] waddr      [2];
  logic [7:0] ren        [2];
  logic [2:0] raddr      [2];
  logic       out_valid  [2];
  logic [5:0] out_index  [2];
  logic       frame_done [2];
`ifdef DA_CTRL_ERR_EN
  logic       err        [2];
`endif

  dif_radix2_64p_da_ctrl #(.RF_DEPTH(8), .RD_LAT(1)) u_lat1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready[0]),
    .wen_ctrl   (wen[0]),
    .waddr_ctrl (waddr[0]),
    .ren_ctrl   (ren[0]),
    .raddr_ctrl (raddr[0]),
    .out_valid  (out_valid[0]),
    .out_index  (out_index[0]),
    .frame_done (frame_done[0])
`ifdef DA_CTRL_ERR_EN
    ,
    .err        (err[0])
`endif
  );

  dif_radix2_64p_da_ctrl #(.RF_DEPTH(8), .RD_LAT(3)) u_lat3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready[1]),
    .wen_ctrl   (wen[1]),
    .waddr_ctrl (waddr[1]),
    .ren_ctrl   (ren[1]),
    .raddr_ctrl (raddr[1]),
    .out_valid  (out_valid[1]),
    .out_index  (out_index[1]),
    .frame_done (frame_done[1])
`ifdef DA_CTRL_ERR_EN
    ,
    .err        (err[1])
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Arranger memory model: 8 banks x 8 entries, read data after RD_LAT.
  logic [7:0] mem   [2][8][8];
  logic [7:0] rpipe [2][3];
  logic [7:0] dout  [2];
  logic [7:0] rd_tmp;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      rd_tmp = 8'hxx;
      for (int b = 0; b < 8; b++) begin
        if (wen[u][b]) mem[u][b][waddr[u]] <= din;
        if (ren[u][b]) rd_tmp = mem[u][b][raddr[u]];
      end
      rpipe[u][0] <= rd_tmp;
      rpipe[u][1] <= rpipe[u][0];
      rpipe[u][2] <= rpipe[u][1];
    end
  end

  assign dout[0] = rpipe[0][0];
  assign dout[1] = rpipe[1][2];

  // Output monitor
  int         k [2] = '{0, 0};
  int         fdone_cnt [2] = '{0, 0};
  logic [7:0] base_q [2][$];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        k[u] = 0;
        base_q[u].delete();
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (frame_done[u]) fdone_cnt[u]++;
        if (out_valid[u]) begin
          if (base_q[u].size() == 0) begin
            chk($sformatf("spurious_out%0d", u), {31'd0, out_valid[u]}, 32'd0);
          end else begin
            int exp_v;
            exp_v = int'(base_q[u][0]) + 8 * (k[u] % 8) + k[u] / 8;
            chk($sformatf("idx%0d_k%0d", u, k[u]), {26'd0, out_index[u]}, k[u]);
            chk($sformatf("dout%0d_k%0d", u, k[u]), {24'd0, dout[u]}, exp_v);
            chk($sformatf("fdone%0d_k%0d", u, k[u]), {31'd0, frame_done[u]}, (k[u] == 63) ? 1 : 0);
            if (k[u] == 0) chk($sformatf("latency%0d", u), cyc - last_acc, 1 + lat_of(u));
            k[u]++;
            if (k[u] == 64) begin
              k[u] = 0;
              void'(base_q[u].pop_front());
            end
          end
        end
      end
    end
  end

  task automatic rst_checks(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_rdy%0d", tag, u), {31'd0, in_ready[u]}, 0);
      chk($sformatf("%s_wen%0d", tag, u), {24'd0, wen[u]}, 0);
      chk($sformatf("%s_waddr%0d", tag, u), {29'd0, waddr[u]}, 0);
      chk($sformatf("%s_ren%0d", tag, u), {24'd0, ren[u]}, 0);
      chk($sformatf("%s_raddr%0d", tag, u), {29'd0, raddr[u]}, 0);
      chk($sformatf("%s_ov%0d", tag, u), {31'd0, out_valid[u]}, 0);
      chk($sformatf("%s_oidx%0d", tag, u), {26'd0, out_index[u]}, 0);
      chk($sformatf("%s_fd%0d", tag, u), {31'd0, frame_done[u]}, 0);
`ifdef DA_CTRL_ERR_EN
      chk($sformatf("%s_err%0d", tag, u), {31'd0, err[u]}, 0);
`endif
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic send_frame(input logic [7:0] base, input bit gaps, input int cnt);
    int n = 0;
    int g = 0;
    logic v;
    while (n < cnt && g < 2000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      din = base + 8'(n);
      #1;
      if (v && in_ready[0]) begin
        for (int u = 0; u < 2; u++) begin
          chk($sformatf("wen%0d_n%0d", u, n), {24'd0, wen[u]}, 32'd1 << (n / 8));
          chk($sformatf("waddr%0d_n%0d", u, n), {29'd0, waddr[u]}, n % 8);
        end
        if (n == cnt - 1 && cnt == 64) begin
          last_acc = cyc;
          base_q[0].push_back(base);
          base_q[1].push_back(base);
        end
        n++;
      end else begin
        for (int u = 0; u < 2; u++) chk($sformatf("wen_idle%0d", u), {24'd0, wen[u]}, 0);
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    chk("send_count", n, cnt);
  endtask

  // Counts in_ready=0 cycles per instance; optionally drives in_valid in
  // READ cycle 10. Returns at the first cycle both accept again.
  task automatic wait_read(input bit inject);
    int c0 = 0;
    int c1 = 0;
    int g = 0;
    while ((in_ready[0] == 1'b0 || in_ready[1] == 1'b0) && g < 200) begin
      in_valid = inject && (c0 == 9);
      din = 8'hEE;
      #1;
      for (int u = 0; u < 2; u++) chk($sformatf("wen_rd%0d", u), {24'd0, wen[u]}, 0);
      if (!in_ready[0]) c0++;
      if (!in_ready[1]) c1++;
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    chk("read_len0", c0, 64);
    chk("read_len1", c1, 64);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_checks("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst0", {31'd0, in_ready[0]}, 1);
    chk("rdy_after_rst1", {31'd0, in_ready[1]}, 1);

    // Frame A: back-to-back, values 0..63
    send_frame(8'd0, 1'b0, 64);
    wait_read(1'b0);

    // Frame B: random gaps, READ cycle 10 sees a stray in_valid
    send_frame(8'd64, 1'b1, 64);
    wait_read(1'b1);
`ifdef DA_CTRL_ERR_EN
    chk("err_set0", {31'd0, err[0]}, 1);
    chk("err_set1", {31'd0, err[1]}, 1);
`endif

    // Frame C: starts in the first cycle after the last read strobe
    send_frame(8'd128, 1'b0, 64);
    wait_read(1'b0);
`ifdef DA_CTRL_ERR_EN
    chk("err_hold0", {31'd0, err[0]}, 1);
    chk("err_hold1", {31'd0, err[1]}, 1);
`endif

    // Partial frame, then reset mid-frame
    send_frame(8'd100, 1'b0, 20);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_checks("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_mid0", {31'd0, in_ready[0]}, 1);
    chk("rdy_after_mid1", {31'd0, in_ready[1]}, 1);

    // Frame D: only this frame may come out after the reset
    send_frame(8'd192, 1'b0, 64);
    wait_read(1'b0);
    repeat (8) @(negedge clk);

    chk("frames0", fdone_cnt[0], 4);
    chk("frames1", fdone_cnt[1], 4);
    chk("pending0", base_q[0].size(), 0);
    chk("pending1", base_q[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
